// File: rtl/w5300_bus_responder.sv
// W5300 8-bit host-bus responder, socket 0 / UDP only: register file, RX/TX FIFOs
// and SEND timer answering the FPGA host-interface initiator.
module w5300_bus_responder #(
  parameter int RX_DEPTH   = 64,
  parameter int SEND_DELAY = 270,
  parameter int TX_SIZE    = 2048
) (
  input  logic       clk,
  input  logic       w5300_nrst_tb,
  input  logic [9:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  output logic       int_n,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       ld_commit,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       err
);
  // state | meaning
  // IDLE  | no send in flight
  // BUSY  | counting down to SENDOK
  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(SEND_DELAY + 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      cs_s, rd_s, wr_s;
  logic            rd_q, wr_q;
  logic            rd_ev, wr_ev;
  logic [7:0]      mr0, mr1;
  logic            recv_ir, sendok_ir;
  logic [1:0]      recv_dly;
  logic [16:0]     tx_fsr, rx_rsr, pend;
  logic [7:0]      mem [RX_DEPTH];
  logic [AW:0]     wptr, rptr, level;
  logic            empty, full, push, pop, pad, pad_drop, pad_need, pad_fits;
  logic [16:0]     pend_total, commit_len, rsr_dec, rsr_next;
  logic            wr_ir, wr_cr, send_cmd, recv_cmd, tx_wr, rx_rd;
  logic            recv_set, sendok_set;
  logic [7:0]      s0_ir, rd_val;
  logic [AW-1:0]   pad_idx;

  assign rd_ev    = rd_q & ~rd_s[1] & ~cs_s[1];
  assign wr_ev    = ~wr_q & wr_s[1] & ~cs_s[1];
  assign data_oe  = ~cs_n & ~rd_n;

  assign wr_ir    = wr_ev && addr == 10'h207;
  assign wr_cr    = wr_ev && addr == 10'h203;
  assign send_cmd = wr_cr && data_in == 8'h20;
  assign recv_cmd = wr_cr && data_in == 8'h40;
  assign tx_wr    = wr_ev && (addr == 10'h22E || addr == 10'h22F);
  assign rx_rd    = rd_ev && (addr == 10'h230 || addr == 10'h231);

  assign empty    = wptr == rptr;
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign ld_ready = ~full;
  assign level    = wptr - rptr;
  assign push     = ld_valid & ~full;
  assign pop      = rx_rd & ~empty;

  // A byte pushed in the commit cycle belongs to that datagram, so the pad goes after it.
  assign pend_total = pend + 17'(push);
  assign pad_need   = ld_commit & pend_total[0];
  assign pad_fits   = (level + PW'(push)) != PW'(RX_DEPTH);
  assign pad        = pad_need & pad_fits;
  assign pad_drop   = pad_need & ~pad_fits;
  assign pad_idx    = wptr[AW-1:0] + AW'(push);
  assign commit_len = pend_total + {16'b0, pend_total[0]};

  assign rsr_dec  = (rx_rd && addr[0]) ? ((rx_rsr >= 17'd2) ? rx_rsr - 17'd2 : 17'd0) : rx_rsr;
  assign rsr_next = ld_commit ? rsr_dec + commit_len : rsr_dec;

  assign sendok_set = state == BUSY && cnt == '0;
  assign recv_set   = ld_commit | recv_dly[1];
  assign s0_ir      = {3'b000, sendok_ir, 1'b0, recv_ir, 2'b00};

  always_comb begin
    rd_val = 8'h00;
    case (addr)
      10'h003:          rd_val = {7'b0, |s0_ir};
      10'h200:          rd_val = mr0;
      10'h201:          rd_val = mr1;
      10'h207:          rd_val = s0_ir;
      10'h225:          rd_val = {7'b0, tx_fsr[16]};
      10'h226:          rd_val = tx_fsr[15:8];
      10'h227:          rd_val = tx_fsr[7:0];
      10'h229:          rd_val = {7'b0, rx_rsr[16]};
      10'h22A:          rd_val = rx_rsr[15:8];
      10'h22B:          rd_val = rx_rsr[7:0];
      10'h230, 10'h231: rd_val = empty ? 8'h00 : mem[rptr[AW-1:0]];
      default:          rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= ld_data;
    if (pad)  mem[pad_idx] <= 8'h00;
  end

  always_ff @(posedge clk or posedge w5300_nrst_tb) begin
    if (w5300_nrst_tb) begin
      cs_s      <= 2'b11;
      rd_s      <= 2'b11;
      wr_s      <= 2'b11;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      data_out  <= 8'h00;
      int_n     <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      err       <= 1'b0;
      mr0       <= 8'h00;
      mr1       <= 8'h00;
      recv_ir   <= 1'b0;
      sendok_ir <= 1'b0;
      recv_dly  <= 2'b00;
      tx_fsr    <= 17'(TX_SIZE);
      rx_rsr    <= '0;
      pend      <= '0;
      wptr      <= '0;
      rptr      <= '0;
      state     <= IDLE;
      cnt       <= '0;
    end else begin
      cs_s     <= {cs_s[0], cs_n};
      rd_s     <= {rd_s[0], rd_n};
      wr_s     <= {wr_s[0], wr_n};
      rd_q     <= rd_s[1];
      wr_q     <= wr_s[1];
      tx_valid <= 1'b0;

      if (rd_ev) data_out <= rd_val;
      if (wr_ev && addr == 10'h200) mr0 <= data_in;
      if (wr_ev && addr == 10'h201) mr1 <= data_in;

      if (tx_wr) begin
        if (tx_fsr == '0) begin
          err <= 1'b1;
        end else begin
          tx_valid <= 1'b1;
          tx_data  <= data_in;
          if (addr[0]) tx_fsr <= (tx_fsr >= 17'd2) ? tx_fsr - 17'd2 : 17'd0;
        end
      end

      if ((rx_rd && empty) || pad_drop) err <= 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      wptr   <= wptr + PW'(push) + PW'(pad);
      pend   <= ld_commit ? 17'd0 : pend_total;
      rx_rsr <= rsr_next;

      recv_dly  <= {recv_dly[0], recv_cmd && rx_rsr != '0};
      // Hardware set beats a same-cycle W1C.
      recv_ir   <= (recv_ir & ~(wr_ir & data_in[2])) | recv_set;
      sendok_ir <= (sendok_ir & ~(wr_ir & data_in[4])) | sendok_set;
      int_n     <= ~(|s0_ir);

      case (state)
        IDLE: if (send_cmd) begin
          cnt   <= CW'(SEND_DELAY);
          state <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          tx_fsr <= 17'(TX_SIZE);
          state  <= IDLE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_w5300_bus_responder.sv
// Self-checking bench for w5300_bus_responder: bus-cycle tasks plus a queue-based
// model of the RX FIFO, RX_RSR, TX_FSR and S0_IR.
module tb_w5300_bus_responder;
  localparam int RX_DEPTH   = 64;
  localparam int SEND_DELAY = 270;
  localparam int TX_SIZE    = 2048;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] addr;
  logic [7:0] data_in, data_out, ld_data, tx_data;
  logic       data_oe, cs_n, rd_n, wr_n, int_n, ld_valid, ld_ready, ld_commit, tx_valid, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_seen[$];
  int         m_rsr, m_pend, m_fsr;
  logic [7:0] m_ir;
  logic       m_err;

  w5300_bus_responder #(.RX_DEPTH(RX_DEPTH), .SEND_DELAY(SEND_DELAY), .TX_SIZE(TX_SIZE)) dut (
    .clk(clk), .w5300_nrst_tb(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .int_n(int_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_commit(ld_commit),
    .tx_valid(tx_valid), .tx_data(tx_data), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_valid) tx_seen.push_back(tx_data);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model_reset();
    rx_q.delete();
    m_rsr = 0; m_pend = 0; m_fsr = TX_SIZE; m_ir = 8'h00; m_err = 1'b0;
  endfunction

  function automatic void model_commit();
    if (m_pend % 2 == 1) begin
      if (rx_q.size() < RX_DEPTH) rx_q.push_back(8'h00);
      else m_err = 1'b1;
      m_pend++;
    end
    m_rsr += m_pend;
    m_pend = 0;
    m_ir |= 8'h04;
  endfunction

  function automatic logic [7:0] model_read(input logic [9:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (rx_q.size() == 0) m_err = 1'b1;
    else v = rx_q.pop_front();
    if (a == 10'h231) m_rsr = (m_rsr >= 2) ? m_rsr - 2 : 0;
    return v;
  endfunction

  task automatic bus_read(input logic [9:0] a, output logic [7:0] d, output logic oe);
    cs_n = 1'b0; addr = a;
    tick();
    rd_n = 1'b0;
    tick(5);
    d = data_out; oe = data_oe;
    rd_n = 1'b1;
    tick();
    cs_n = 1'b1;
    tick(2);
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [7:0] d);
    cs_n = 1'b0; addr = a; data_in = d;
    tick();
    wr_n = 1'b0;
    tick(2);
    wr_n = 1'b1;
    tick(4);
    cs_n = 1'b1;
    tick(2);
  endtask

  // mode 0: bytes 0,1,2..; otherwise random. commit_last pulses ld_commit with the last byte.
  task automatic load_bytes(input int n, input int mode, input bit commit_last);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = (mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      ld_commit = commit_last && (i == n - 1);
      if (rx_q.size() < RX_DEPTH) begin
        rx_q.push_back(ld_data);
        m_pend++;
      end
      if (ld_commit) model_commit();
      tick();
    end
    ld_valid = 1'b0; ld_commit = 1'b0;
  endtask

  task automatic do_commit();
    ld_commit = 1'b1;
    model_commit();
    tick();
    ld_commit = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] d; logic oe; logic [7:0] exp;
    checks++;
    if ({int_n, err, ld_ready, tx_valid, data_oe} !== 5'b10100 || data_out !== 8'h00 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got int_n=%b err=%b ld_ready=%b tx_valid=%b oe=%b dout=%02h txd=%02h want 1 0 1 0 0 00 00",
               int_n, err, ld_ready, tx_valid, data_oe, data_out, tx_data);
    end
    for (int k = 0; k < 4; k++) begin
      exp = 8'((m_fsr >> (8 * (3 - k))) & 255);
      bus_read(10'h224 + 10'(k), d, oe);
      checks++;
      if (d !== exp || oe !== 1'b1) begin
        errors++; $display("FAIL reset_fsr%0d got %02h oe=%b want %02h oe=1", k, d, oe, exp);
      end
    end
    checks++;
    if (data_oe !== 1'b0) begin errors++; $display("FAIL oe_release got %b want 0", data_oe); end
    bus_read(10'h22B, d, oe);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_rsr got %02h want 00", d); end
  endtask

  task automatic test_regs();
    logic [7:0] d, v0, v1; logic oe;
    v0 = 8'($urandom_range(1, 255)); v1 = 8'($urandom_range(1, 255));
    bus_write(10'h200, v0);
    bus_write(10'h201, v1);
    bus_write(10'h100, 8'hA5);
    bus_read(10'h200, d, oe);
    checks++; if (d !== v0) begin errors++; $display("FAIL mr0 got %02h want %02h", d, v0); end
    bus_read(10'h201, d, oe);
    checks++; if (d !== v1) begin errors++; $display("FAIL mr1 got %02h want %02h", d, v1); end
    bus_read(10'h100, d, oe);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped got %02h want 00", d); end
    bus_read(10'h203, d, oe);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL cr_read got %02h want 00", d); end
    bus_read(10'h002, d, oe);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ir0 got %02h want 00", d); end
  endtask

  task automatic test_rx_basic();
    logic [7:0] d, exp; logic oe; logic [9:0] a;
    load_bytes(10, 0, 1'b0);
    ld_commit = 1'b1; model_commit(); tick(); ld_commit = 1'b0; tick();
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL recv_int got %b want 0", int_n); end
    bus_read(10'h003, d, oe);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL ir1 got %02h want 01", d); end
    bus_read(10'h207, d, oe);
    checks++; if (d !== m_ir) begin errors++; $display("FAIL s0_ir got %02h want %02h", d, m_ir); end
    for (int k = 0; k < 4; k++) begin
      exp = 8'((m_rsr >> (8 * (3 - k))) & 255);
      bus_read(10'h228 + 10'(k), d, oe);
      checks++; if (d !== exp) begin errors++; $display("FAIL rsr%0d got %02h want %02h", k, d, exp); end
    end
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? 10'h230 : 10'h231;
      exp = model_read(a);
      bus_read(a, d, oe);
      checks++; if (d !== exp) begin errors++; $display("FAIL rx_byte%0d got %02h want %02h", i, d, exp); end
    end
    bus_read(10'h22B, d, oe);
    checks++; if (d !== 8'(m_rsr)) begin errors++; $display("FAIL rsr_drained got %02h want %02h", d, 8'(m_rsr)); end
  endtask

  task automatic test_pad();
    logic [7:0] d, exp; logic oe; logic [9:0] a;
    load_bytes(3, 1, 1'b0);
    do_commit();
    bus_read(10'h22B, d, oe);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL pad_rsr got %02h want 04", d); end
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 10'h230 : 10'h231;
      exp = model_read(a);
      bus_read(a, d, oe);
      checks++; if (d !== exp) begin errors++; $display("FAIL pad_byte%0d got %02h want %02h", i, d, exp); end
    end
    m_ir &= ~8'h04;
    bus_write(10'h207, 8'h04);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL w1c_recv int_n got %b want 1", int_n); end
  endtask

  task automatic test_send();
    logic [7:0] d, exp; logic oe; logic [7:0] sent[4];
    load_bytes(2, 1, 1'b1);
    tick(2);
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL send_pre_int got %b want 0", int_n); end
    bus_write(10'h203, 8'h20);
    tx_seen.delete();
    for (int i = 0; i < 4; i++) begin
      sent[i] = 8'($urandom_range(0, 255));
      bus_write((i % 2 == 0) ? 10'h22E : 10'h22F, sent[i]);
      if (i % 2 == 1) m_fsr -= 2;
    end
    checks++;
    if (tx_seen.size() != 4) begin errors++; $display("FAIL tx_count got %0d want 4", tx_seen.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_seen[i] !== sent[i]) begin errors++; $display("FAIL tx_byte%0d got %02h want %02h", i, tx_seen[i], sent[i]); end
    end
    bus_read(10'h226, d, oe);
    checks++; if (d !== 8'(m_fsr >> 8)) begin errors++; $display("FAIL fsr_hi got %02h want %02h", d, 8'(m_fsr >> 8)); end
    bus_read(10'h227, d, oe);
    checks++; if (d !== 8'(m_fsr)) begin errors++; $display("FAIL fsr_lo got %02h want %02h", d, 8'(m_fsr)); end
    tick(300);
    m_ir |= 8'h10; m_fsr = TX_SIZE;
    bus_read(10'h207, d, oe);
    checks++; if (d !== m_ir) begin errors++; $display("FAIL sendok_ir got %02h want %02h", d, m_ir); end
    bus_read(10'h226, d, oe);
    checks++; if (d !== 8'(m_fsr >> 8)) begin errors++; $display("FAIL fsr_restore got %02h want %02h", d, 8'(m_fsr >> 8)); end
    m_ir &= ~8'h10;
    bus_write(10'h207, 8'h10);
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL w1c_sendok int_n got %b want 0", int_n); end
    m_ir &= ~8'h04;
    bus_write(10'h207, 8'h04);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL w1c_all int_n got %b want 1", int_n); end
    while (rx_q.size() > 0) begin
      exp = model_read(10'h231);
      bus_read(10'h231, d, oe);
      checks++; if (d !== exp) begin errors++; $display("FAIL send_drain got %02h want %02h", d, exp); end
    end
  endtask

  // wr_n rise -> event edge is 3 clk (2 sync + edge detect), SENDOK SEND_DELAY+1 after, int_n 1 more.
  task automatic test_send_timing();
    int cycles;
    cs_n = 1'b0; addr = 10'h203; data_in = 8'h20;
    tick();
    wr_n = 1'b0;
    tick(2);
    wr_n = 1'b1;
    cycles = 0;
    while (int_n === 1'b1 && cycles < 400) begin
      tick();
      cycles++;
      case (cycles)
        8:  cs_n = 1'b0;
        20: wr_n = 1'b0;
        22: wr_n = 1'b1;
        30: cs_n = 1'b1;
        default: ;
      endcase
    end
    checks++;
    if (cycles != SEND_DELAY + 5) begin
      errors++; $display("FAIL send_latency got %0d want %0d", cycles, SEND_DELAY + 5);
    end
    cs_n = 1'b1;
    tick(4);
    m_ir = 8'h00; m_fsr = TX_SIZE;
    bus_write(10'h207, 8'h10);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL timing_clear int_n got %b want 1", int_n); end
  endtask

  task automatic test_recv_cmd();
    logic [7:0] d, exp; logic oe;
    bus_write(10'h203, 8'h40);
    bus_read(10'h207, d, oe);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL recv_cmd_empty got %02h want 00", d); end
    load_bytes(2, 1, 1'b1);
    m_ir &= ~8'h04;
    bus_write(10'h207, 8'h04);
    if (m_rsr != 0) m_ir |= 8'h04;
    bus_write(10'h203, 8'h40);
    bus_read(10'h207, d, oe);
    checks++; if (d !== m_ir) begin errors++; $display("FAIL recv_cmd_set got %02h want %02h", d, m_ir); end
    m_ir = 8'h00;
    bus_write(10'h207, 8'h04);
    while (rx_q.size() > 0) begin
      exp = model_read(10'h231);
      bus_read(10'h231, d, oe);
      checks++; if (d !== exp) begin errors++; $display("FAIL recv_drain got %02h want %02h", d, exp); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d, exp; logic oe; logic [9:0] a; int nrd;
    for (int it = 0; it < 15; it++) begin
      load_bytes($urandom_range(1, 9), 1, 1'($urandom_range(0, 1)));
      if (m_pend != 0) do_commit();
      nrd = (rx_q.size() > 40) ? rx_q.size() : $urandom_range(0, rx_q.size());
      for (int r = 0; r < nrd; r++) begin
        a = $urandom_range(0, 1) ? 10'h231 : 10'h230;
        exp = model_read(a);
        bus_read(a, d, oe);
        checks++; if (d !== exp) begin errors++; $display("FAIL rnd%0d_byte%0d got %02h want %02h", it, r, d, exp); end
      end
      bus_read(10'h22B, d, oe);
      checks++; if (d !== 8'(m_rsr)) begin errors++; $display("FAIL rnd%0d_rsr got %02h want %02h", it, d, 8'(m_rsr)); end
    end
    while (rx_q.size() > 0) begin
      exp = model_read(10'h230);
      bus_read(10'h230, d, oe);
      checks++; if (d !== exp) begin errors++; $display("FAIL rnd_drain got %02h want %02h", d, exp); end
    end
    bus_read(10'h207, d, oe);
    checks++; if (d !== m_ir || int_n !== (m_ir == 0)) begin
      errors++; $display("FAIL rnd_ir got %02h int_n=%b want %02h", d, int_n, m_ir);
    end
    m_ir = 8'h00;
    bus_write(10'h207, 8'hFF);
    checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err got %b want %b", err, m_err); end
  endtask

  task automatic test_underflow();
    logic [7:0] d, exp; logic oe;
    exp = model_read(10'h230);
    bus_read(10'h230, d, oe);
    checks++;
    if (d !== exp || err !== m_err) begin
      errors++; $display("FAIL underflow got %02h err=%b want %02h err=%b", d, err, exp, m_err);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] d; logic oe;
    bus_write(10'h203, 8'h20);
    tick(100);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(400);
    checks++;
    if ({int_n, err, ld_ready, tx_valid, data_oe} !== 5'b10100 || data_out !== 8'h00 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL midsend_outputs got int_n=%b err=%b ld_ready=%b tx_valid=%b oe=%b dout=%02h txd=%02h",
               int_n, err, ld_ready, tx_valid, data_oe, data_out, tx_data);
    end
    bus_read(10'h207, d, oe);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midsend_ir got %02h want 00", d); end
    bus_read(10'h226, d, oe);
    checks++; if (d !== 8'(m_fsr >> 8)) begin errors++; $display("FAIL midsend_fsr got %02h want %02h", d, 8'(m_fsr >> 8)); end
  endtask

  task automatic test_full();
    logic [7:0] d, exp; logic oe;
    load_bytes(RX_DEPTH + 2, 1, 1'b0);
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ld_ready); end
    checks++; if (err !== m_err) begin errors++; $display("FAIL full_err got %b want %b", err, m_err); end
    exp = model_read(10'h230);
    bus_read(10'h230, d, oe);
    checks++; if (d !== exp) begin errors++; $display("FAIL full_pop got %02h want %02h", d, exp); end
    load_bytes(1, 1, 1'b1);
    tick();
    checks++; if (err !== m_err) begin errors++; $display("FAIL pad_drop_err got %b want %b", err, m_err); end
    bus_read(10'h22B, d, oe);
    checks++; if (d !== 8'(m_rsr)) begin errors++; $display("FAIL full_rsr got %02h want %02h", d, 8'(m_rsr)); end
    while (rx_q.size() > 0) begin
      exp = model_read(10'h230);
      bus_read(10'h230, d, oe);
      checks++; if (d !== exp) begin errors++; $display("FAIL full_drain got %02h want %02h", d, exp); end
    end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL drained_ready got %b want 1", ld_ready); end
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = '0; data_in = '0;
    ld_valid = 1'b0; ld_data = '0; ld_commit = 1'b0;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(3);
    test_reset();
    test_regs();
    test_rx_basic();
    test_pad();
    test_send();
    test_send_timing();
    test_recv_cmd();
    test_random();
    test_underflow();
    test_reset_mid_send();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/w5300_bus_responder.md
# w5300_bus_responder

- Synthesizable model of the W5300 8-bit host-bus responder, reduced to socket 0 in UDP mode.
- Answers the FPGA host-interface initiator's rd/wr/cs cycles with a register file and RX/TX FIFOs, and drives int_n for RECV and SENDOK.
- A side-band loader injects received datagrams.
- Used in bench and bring-up builds in place of the real chip.

## Interface
Parameters:
- RX_DEPTH, 64, RX FIFO depth in bytes (power of two, ≥4)
- SEND_DELAY, 270, clk cycles from SEND command to SENDOK (10 µs at 27 MHz)
- TX_SIZE, 2048, free size reported when the TX buffer is idle

Ports:
- clk  in  1  system clock
- w5300_nrst_tb  in  1  reset, asynchronous, active-high
- addr  in  10  host address bus
- data_in  in  8  host write data
- data_out  out  8  read data
- data_oe  out  1  data_out drive enable
- cs_n, rd_n, wr_n  in  1 each  host strobes, active-low, asynchronous to clk
- int_n  out  1  interrupt, active-low
- ld_valid  in  1  RX loader byte valid
- ld_data  in  8  RX loader byte
- ld_ready  out  1  RX FIFO not full
- ld_commit  in  1  one-cycle pulse that closes a datagram
- tx_valid  out  1  one-cycle pulse per TX FIFO byte accepted
- tx_data  out  8  accepted TX byte
- err  out  1  sticky error: RX underflow or TX overflow

## Operation
Strobes:
- cs_n, rd_n and wr_n each pass through a 2-flop synchronizer.
- A read event is a falling edge of synced rd_n while synced cs_n is low.
- A write event is a rising edge of synced wr_n while synced cs_n is low.
- addr and data_in are sampled on the write-event clk.

Register map (8-bit mode). Unmapped addresses read 0x00 and ignore writes.
- 0x002 IR0: reads 0x00.
- 0x003 IR1: bit0 = |S0_IR; read-only.
- 0x200 S0_MR0: read/write, 8 bits.
- 0x201 S0_MR1: read/write, 8 bits.
- 0x203 S0_CR: write-only, reads 0x00.
  - 0x20 SEND starts the send timer.
  - 0x40 RECV: if RX_RSR≠0, sets RECV again 2 clk later.
  - All other values are ignored.
- 0x207 S0_IR: W1C. bit2 = RECV, bit4 = SENDOK. 0x206 reads 0x00.
- 0x224..0x227 S0_TX_FSR: 17-bit value, big-endian bytes, top byte 0.
- 0x228..0x22B S0_RX_RSR: 17-bit value, same format.
- 0x22E/0x22F TX FIFO write:
  - Each write pulses tx_valid/tx_data.
  - A write to 0x22F also subtracts 2 from TX_FSR.
  - A write while TX_FSR==0 is dropped and sets err.
- 0x230/0x231 RX FIFO read:
  - Each read pops one byte.
  - A read of 0x231 also subtracts 2 from RX_RSR (saturating at 0).
  - A read with the FIFO empty returns 0x00 and sets err.

Loader:
- A byte is pushed when ld_valid && ld_ready. pend counts bytes pushed since the last commit.
- On ld_commit:
  - If pend is odd, one 0x00 pad byte is pushed first.
  - If the FIFO is full at that point, the pad is dropped and err is set.
  - Then RX_RSR += padded pend, pend ← 0, and RECV is set.
- A simultaneous push and commit counts the pushed byte in that commit.

Send FSM:
- States IDLE, BUSY.
- SEND in IDLE: load counter with SEND_DELAY → BUSY.
- SEND while BUSY: ignored.
- BUSY counts down to 0, then: set SENDOK, TX_FSR ← TX_SIZE, → IDLE.

Interrupts and conflicts:
- int_n = ~(|S0_IR); registered.
- A hardware set and a W1C of the same bit in the same clk: the set wins.

RX FIFO pointers are log2(RX_DEPTH)+1 bits with natural wrap; full/empty are decoded from the MSB.

## Timing
- Reset values: data_out=0x00, data_oe=0, int_n=1, ld_ready=1, tx_valid=0, tx_data=0x00, err=0. Also S0_IR=0, MR=0, RX_RSR=0, TX_FSR=TX_SIZE, FIFO empty, FSM IDLE.
- Asserting reset mid-send clears the timer; no SENDOK is produced.
- data_oe = raw ~cs_n & ~rd_n (combinational, so the bus releases immediately).
- data_out is registered on the read event: valid ≤3 clk after rd_n falls. The host holds rd_n low ≥4 clk.
- Host holds addr/data_in ≥3 clk after wr_n rises. The register update is visible on the clk after the write event.
- int_n deasserts 2 clk after the W1C write event that clears the last set bit.
- SENDOK is set SEND_DELAY+1 clk after the S0_CR write event.
- The loader accepts 1 byte/clk.

## Test plan
- Reset, then read 0x224..0x227 → 00 00 08 00; read 0x22B → 00; int_n=1.
- Load 10 bytes 0..9, then ld_commit:
  - int_n low within 2 clk; IR1=0x01; S0_IR=0x04; RSR bytes 00 00 00 0A.
  - 10 alternating 0x230/0x231 reads → 0..9; RSR=0.
- Load 3 bytes, then commit → RSR=4; 4th byte read = 0x00 (pad).
- Write 0x04 to 0x207 → int_n high 2 clk later.
- Set RECV by a loader commit (S0_IR=0x04, int_n low); write 0x20 to 0x203; 2 TX words:
  - FSR reads 0x07FC.
  - SENDOK asserts 271 clk after the CR write; S0_IR=0x14; int_n stays low.
  - W1C 0x10 leaves int_n low; W1C 0x04 drives it high.
- Read 0x230 with the FIFO empty → 0x00 and err=1.
- Fill RX_DEPTH bytes → ld_ready=0.
- Assert reset 100 clk after a SEND → no SENDOK and all outputs at reset values.
